mod_counter_gen2: RTL and testbench

//  Parametrised modulo counter: up/down, wrap or saturate, run-time limit

---
 rtl/mod_counter_gen2.sv | 83 ++++++++
 tb/tb_mod_counter_gen2.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/mod_counter_gen2.sv
// Modulo counter: up/down, wrap or saturate, run-time limit register, load, registered tc.
// Optional WRAP_CNT_EN adds a saturating wrap-event counter on port wrap_cnt.
module mod_counter_gen2 #(
   parameter int WIDTH    = 8,
   parameter int MOD_MAX  = 10,
   parameter int IDLE_CLR = 1,
   parameter int WRAP_W   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             cnt_en,
   input  logic             dir,
   input  logic             mode,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   input  logic             limit_wr,
   input  logic [WIDTH-1:0] limit_val,
   output logic [WIDTH-1:0] out,
   output logic [WIDTH-1:0] limit,
   output logic             tc
`ifdef WRAP_CNT_EN
   ,
   output logic [WRAP_W-1:0] wrap_cnt
`endif
);

   localparam logic [WIDTH-1:0] LP_LIMIT_RST = WIDTH'(MOD_MAX);

   logic [WIDTH-1:0] r_out;
   logic [WIDTH-1:0] r_limit;
   logic             r_tc;
   logic [WIDTH-1:0] w_out_nxt;
   logic             w_term;

   // Count and load decisions both use the limit as it stood before this edge.
   always_comb begin
      w_term    = cnt_en & ~load &
                  ((dir & (r_out >= r_limit)) | (~dir & (r_out == '0)));
      w_out_nxt = r_out;
      if (load) begin
         w_out_nxt = (load_val > r_limit) ? r_limit : load_val;
      end else if (cnt_en) begin
         if (dir) begin
            if (r_out < r_limit) w_out_nxt = r_out + WIDTH'(1);
            else                 w_out_nxt = mode ? r_limit : '0;
         end else begin
            if (r_out > r_limit)     w_out_nxt = r_limit;
            else if (r_out == '0)    w_out_nxt = mode ? '0 : r_limit;
            else                     w_out_nxt = r_out - WIDTH'(1);
         end
      end else if (IDLE_CLR != 0) begin
         w_out_nxt = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out   <= '0;
         r_tc    <= 1'b0;
         r_limit <= LP_LIMIT_RST;
      end else begin
         r_out <= w_out_nxt;
         r_tc  <= w_term;
         if (limit_wr) r_limit <= limit_val;
      end
   end

   assign out   = r_out;
   assign limit = r_limit;
   assign tc    = r_tc;

`ifdef WRAP_CNT_EN
   logic [WRAP_W-1:0] r_wrap;

   always_ff @(posedge clk) begin
      if (rst || load)                          r_wrap <= '0;
      else if (w_term && !mode && r_wrap != '1) r_wrap <= r_wrap + WRAP_W'(1);
   end

   assign wrap_cnt = r_wrap;
`endif

endmodule

// File: tb/tb_mod_counter_gen2.sv
// Scoreboard bench for mod_counter_gen2: directed vectors queue expectations, a monitor checks each cycle.
module tb_mod_counter_gen2;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       cnt_en = 1'b0;
   logic       dir = 1'b1;
   logic       mode = 1'b0;
   logic       load = 1'b0;
   logic [7:0] load_val = '0;
   logic       limit_wr = 1'b0;
   logic [7:0] limit_val = '0;
   logic [7:0] out, limit, out_h, limit_h;
   logic       tc, tc_h;
`ifdef WRAP_CNT_EN
   logic [7:0] wrap_cnt, wrap_h;
`endif

   always #5 clk = ~clk;

   mod_counter_gen2 #(.WIDTH(8), .MOD_MAX(10), .IDLE_CLR(1), .WRAP_W(8)) dut (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .limit_wr(limit_wr), .limit_val(limit_val),
      .out(out), .limit(limit), .tc(tc)
`ifdef WRAP_CNT_EN
      , .wrap_cnt(wrap_cnt)
`endif
   );

   // Same stimulus into a hold-on-idle variant
   mod_counter_gen2 #(.WIDTH(8), .MOD_MAX(10), .IDLE_CLR(0), .WRAP_W(8)) dut_h (
      .clk(clk), .rst(rst), .cnt_en(cnt_en), .dir(dir), .mode(mode),
      .load(load), .load_val(load_val), .limit_wr(limit_wr), .limit_val(limit_val),
      .out(out_h), .limit(limit_h), .tc(tc_h)
`ifdef WRAP_CNT_EN
      , .wrap_cnt(wrap_h)
`endif
   );

   typedef struct {
      string      nm;
      logic [7:0] o;
      logic       t;
      logic [7:0] l;
      bit         ch;
      logic [7:0] oh;
      bit         cw;
      logic [7:0] w;
   } exp_t;

   exp_t q[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic s(input string nm, input logic r, input logic en, input logic d, input logic m,
                    input logic ld, input logic [7:0] lv, input logic lw, input logic [7:0] lwv,
                    input logic [7:0] eo, input logic et, input logic [7:0] el,
                    input bit ch = 0, input logic [7:0] eh = 0,
                    input bit cw = 0, input logic [7:0] ew = 0);
      exp_t e;
      @(negedge clk);
      rst = r; cnt_en = en; dir = d; mode = m;
      load = ld; load_val = lv; limit_wr = lw; limit_val = lwv;
      e.nm = nm; e.o = eo; e.t = et; e.l = el;
      e.ch = ch; e.oh = eh; e.cw = cw; e.w = ew;
      q.push_back(e);
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk({e.nm, ".out"}, out, e.o);
            chk({e.nm, ".tc"}, {7'b0, tc}, {7'b0, e.t});
            chk({e.nm, ".limit"}, limit, e.l);
            if (e.ch) begin
               chk({e.nm, ".out_h"}, out_h, e.oh);
               chk({e.nm, ".tc_h"}, {7'b0, tc_h}, {7'b0, e.t});
               chk({e.nm, ".limit_h"}, limit_h, e.l);
            end
`ifdef WRAP_CNT_EN
            if (e.cw) chk({e.nm, ".wrap_cnt"}, wrap_cnt, e.w);
            if (e.cw && e.ch) chk({e.nm, ".wrap_h"}, wrap_h, e.w);
`endif
         end
      end
   end

   initial begin : stim
      //  name      rst en dir mode ld lv lw lwv  out tc lim  [ch oh cw w]
      s("rst",      1, 0, 1, 0, 0, 0, 0, 0,   0, 0, 10, 1, 0, 1, 0);

      for (int i = 1; i <= 13; i++)
         s("t1_up", 0, 1, 1, 0, 0, 0, 0, 0, (i <= 10) ? 8'(i) : 8'(i - 11), i == 11, 10,
           0, 0, i == 13, 1);

      for (int i = 1; i <= 14; i++)
         s("t2_sat", 0, 1, 1, 1, 0, 0, 0, 0, (i + 2 > 10) ? 8'd10 : 8'(i + 2), i >= 9, 10,
           0, 0, i == 14, 1);
      s("t2_idle",  0, 0, 1, 1, 0, 0, 0, 0,   0, 0, 10);

      s("t3_ld3",   0, 0, 0, 0, 1, 3, 0, 0,   3, 0, 10, 0, 0, 1, 0);
      s("t3_dn2",   0, 1, 0, 0, 0, 0, 0, 0,   2, 0, 10);
      s("t3_dn1",   0, 1, 0, 0, 0, 0, 0, 0,   1, 0, 10);
      s("t3_dn0",   0, 1, 0, 0, 0, 0, 0, 0,   0, 0, 10);
      s("t3_dnwrap",0, 1, 0, 0, 0, 0, 0, 0,  10, 1, 10, 0, 0, 1, 1);
      s("t3_dn9",   0, 1, 0, 0, 0, 0, 0, 0,   9, 0, 10);
      s("t3_ld200", 0, 0, 0, 0, 1, 200, 0, 0, 10, 0, 10, 0, 0, 1, 0);

      s("t4_ld8",   0, 0, 1, 0, 1, 8, 0, 0,   8, 0, 10);
      s("t4_upwr5", 0, 1, 1, 0, 0, 0, 1, 5,   9, 0, 5);
      s("t4_wrap",  0, 1, 1, 0, 0, 0, 0, 0,   0, 1, 5, 0, 0, 1, 1);
      s("t4_ldold", 0, 0, 1, 0, 1, 8, 1, 10,  5, 0, 10);
      s("t4_ld8b",  0, 0, 1, 0, 1, 8, 0, 0,   8, 0, 10);
      s("t4_satwr5",0, 1, 1, 1, 0, 0, 1, 5,   9, 0, 5);
      s("t4_sat",   0, 1, 1, 1, 0, 0, 0, 0,   5, 1, 5);
      s("t4_pin",   0, 1, 1, 1, 0, 0, 0, 0,   5, 1, 5);
      s("t4_lim0",  0, 0, 1, 0, 0, 0, 1, 0,   0, 0, 0);
      s("t4_z_up",  0, 1, 1, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 1);
      s("t4_z_dn",  0, 1, 0, 0, 0, 0, 0, 0,   0, 1, 0, 0, 0, 1, 2);
      s("t4_lim10", 0, 0, 1, 0, 0, 0, 1, 10,  0, 0, 10);

      s("t5_ld4",   0, 0, 1, 0, 1, 4, 0, 0,   4, 0, 10);
      s("t5_ldcnt", 0, 1, 1, 0, 1, 7, 0, 0,   7, 0, 10, 1, 7, 1, 0);
      s("t5_idle",  0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 10, 1, 7);
      s("t5_idle2", 0, 0, 1, 0, 0, 0, 0, 0,   0, 0, 10, 1, 7);

      s("w_lim1",   0, 0, 1, 0, 0, 0, 1, 1,   0, 0, 1);
      for (int i = 1; i <= 6; i++)
         s("w_up", 0, 1, 1, 0, 0, 0, 0, 0, 8'(i % 2), (i % 2) == 0, 1, 0, 0, i == 6, 3);
      s("w_lim10",  0, 0, 1, 0, 0, 0, 1, 10,  0, 0, 10, 0, 0, 1, 3);

      for (int i = 1; i <= 6; i++)
         s("t6_up", 0, 1, 1, 0, 0, 0, 0, 0, 8'(i), 0, 10);
      s("t6_upwr5", 0, 1, 1, 0, 0, 0, 1, 5,   7, 0, 5, 0, 0, 1, 3);
      s("t6_rst",   1, 1, 1, 0, 0, 0, 0, 0,   0, 0, 10, 1, 0, 1, 0);

      @(negedge clk);
      rst = 1'b0; cnt_en = 1'b0; load = 1'b0; limit_wr = 1'b0;
      for (int k = 0; k < 5 && q.size() > 0; k++) @(negedge clk);
      if (q.size() != 0) begin
         n_bad++;
         $display("FAIL drain: %0d expectations left, expected 0", q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
